// File: rtl/mac_accumulator.sv
// mac_accumulator: sums KERNEL_SIZE products per window and hands the sum downstream via valid/ready.
// Define ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module mac_accumulator #(
  parameter int BIT_WIDTH   = 8,
  parameter int KERNEL_SIZE = 9,
  parameter int ACC_WIDTH   = 20
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [2*BIT_WIDTH-1:0] i_product,
  input  logic                   i_product_valid,
  input  logic                   i_start,
  output logic                   o_in_ready,
  output logic [ACC_WIDTH-1:0]   o_sum,
  output logic                   o_sum_valid,
  input  logic                   i_sum_ready,
  output logic                   o_overflow,
  output logic                   o_drop
);
  localparam int CW = $clog2(KERNEL_SIZE + 1);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_nx;
  logic [ACC_WIDTH-1:0] acc, acc_nx, prod_x;
  logic [CW-1:0] cnt, cnt_nx;
  logic [ACC_WIDTH:0] sum;
  logic accept, ovf_nx, drop_nx;
  assign o_in_ready  = i_rst_n & ((state != HOLD) | i_sum_ready);
  assign accept      = i_product_valid & o_in_ready;
  assign prod_x      = ACC_WIDTH'(i_product);
  assign sum         = {1'b0, acc} + {1'b0, prod_x};
  assign o_sum       = acc;
  assign o_sum_valid = state == HOLD;
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    ovf_nx   = o_overflow;
    drop_nx  = 1'b0;
    if (accept & i_start) begin
      acc_nx   = prod_x;
      cnt_nx   = CW'(1);
      ovf_nx   = 1'b0;
      drop_nx  = state == ACCUM;
      state_nx = (KERNEL_SIZE == 1) ? HOLD : ACCUM;
    end else if (accept & (state == ACCUM)) begin
`ifdef ACC_SATURATE_EN
      acc_nx   = (o_overflow | sum[ACC_WIDTH]) ? '1 : sum[ACC_WIDTH-1:0];
`else
      acc_nx   = sum[ACC_WIDTH-1:0];
`endif
      ovf_nx   = o_overflow | sum[ACC_WIDTH];
      cnt_nx   = cnt + CW'(1);
      state_nx = (cnt == CW'(KERNEL_SIZE - 1)) ? HOLD : ACCUM;
    end else begin
      // only stray products in IDLE/HOLD reach here accepted
      drop_nx  = accept;
      state_nx = (state == HOLD & i_sum_ready) ? IDLE : state;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      o_overflow <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      state      <= state_nx;
      acc        <= acc_nx;
      cnt        <= cnt_nx;
      o_overflow <= ovf_nx;
      o_drop     <= drop_nx;
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: table vectors, directed corner sequences and random traffic vs a full-precision window model.
module tb_mac_accumulator;
  localparam int K  = 9;
  localparam int AW = 20;
  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic [15:0] i_product = '0;
  logic        i_product_valid = 1'b0, i_start = 1'b0, i_sum_ready = 1'b0;
  logic        o_in_ready, o_sum_valid, o_overflow, o_drop;
  logic [19:0] o_sum;
  logic [15:0] p2 = '0;
  logic        v2 = 1'b0, s2 = 1'b0, r2 = 1'b0;
  logic        rdy2, sv2, ov2, dr2;
  logic [16:0] sum2;

  mac_accumulator #(.BIT_WIDTH(8), .KERNEL_SIZE(K), .ACC_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_product(i_product), .i_product_valid(i_product_valid),
    .i_start(i_start), .o_in_ready(o_in_ready), .o_sum(o_sum), .o_sum_valid(o_sum_valid),
    .i_sum_ready(i_sum_ready), .o_overflow(o_overflow), .o_drop(o_drop));

  mac_accumulator #(.BIT_WIDTH(8), .KERNEL_SIZE(3), .ACC_WIDTH(17)) dut2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_product(p2), .i_product_valid(v2),
    .i_start(s2), .o_in_ready(rdy2), .o_sum(sum2), .o_sum_valid(sv2),
    .i_sum_ready(r2), .o_overflow(ov2), .o_drop(dr2));

  always #5 i_clk = ~i_clk;

  int total = 0, bad = 0, drops = 0;
  bit m_hold = 0, m_busy = 0, m_drop = 0;
  longint m_acc = 0;
  int m_n = 0;

  typedef struct {
    bit v, s; logic [15:0] p; bit r;
    bit ev; int es; bit ed;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint fold(input longint a, input int w);
`ifdef ACC_SATURATE_EN
    return (a >= (64'sd1 <<< w)) ? (64'sd1 <<< w) - 1 : a;
`else
    return a % (64'sd1 <<< w);
`endif
  endfunction

  // Entered at posedge+1; drives one cycle of inputs, advances the window model, checks after the edge.
  task automatic step(input bit v, input bit s, input logic [15:0] p, input bit r);
    bit rdy, acc;
    i_product_valid = v; i_start = s; i_product = p; i_sum_ready = r;
    #1;
    rdy = !m_hold | r;
    chk("in_ready", o_in_ready, rdy);
    @(posedge i_clk);
    acc = v & rdy;
    m_drop = 0;
    if (m_hold & r) m_hold = 0;
    if (acc) begin
      if (s) begin
        m_drop = m_busy; m_acc = p; m_n = 1; m_busy = 1;
      end else if (m_busy) begin
        m_acc += p; m_n++;
      end else m_drop = 1;
    end
    if (m_busy && m_n == K) begin m_hold = 1; m_busy = 0; end
    #1;
    chk("sum_valid", o_sum_valid, m_hold);
    if (m_hold) chk("sum", o_sum, fold(m_acc, AW));
    chk("overflow", o_overflow, m_acc >= (64'sd1 <<< AW));
    chk("drop", o_drop, m_drop);
    drops += o_drop;
  endtask

  initial begin
    for (int i = 0; i < 9; i++) tbl.push_back('{1, i == 0, 16'd65025, 1, i == 8, 585225, 0});
    tbl.push_back('{0, 0, 16'd0, 1, 0, 0, 0});
    for (int i = 1; i <= 4; i++) tbl.push_back('{1, i == 1, 16'(i), 1, 0, 0, 0});
    for (int i = 0; i < 9; i++) tbl.push_back('{1, i == 0, 16'd2, 1, i == 8, 18, i == 0});
    tbl.push_back('{0, 0, 16'd0, 1, 0, 0, 0});

    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_in_ready", o_in_ready, 0);
    chk("rst_sum_valid", o_sum_valid, 0);
    chk("rst_sum", o_sum, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_drop", o_drop, 0);
    i_rst_n = 1;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].s, tbl[i].p, tbl[i].r);
      chk("tbl_valid", o_sum_valid, tbl[i].ev);
      if (tbl[i].ev) chk("tbl_sum", o_sum, tbl[i].es);
      chk("tbl_drop", o_drop, tbl[i].ed);
    end

    for (int i = 1; i <= 9; i++) begin
      step(1, i == 1, 16'(i), 0);
      step(0, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 16'd99, 0);
      chk("held_sum", o_sum, 45);
      chk("held_in_ready", o_in_ready, 0);
    end
    step(0, 0, 0, 1);
    chk("held_release", o_sum_valid, 0);

    drops = 0;
    for (int i = 1; i <= 9; i++) step(1, i == 1, 16'(i), 0);
    chk("b2b_sum1", o_sum, 45);
    step(1, 1, 16'd2, 1);
    for (int i = 2; i <= 9; i++) step(1, 0, 16'(2 * i), 0);
    chk("b2b_sum2", o_sum, 90);
    step(0, 0, 0, 1);
    chk("b2b_drops", drops, 0);

    i_product_valid = 0; i_sum_ready = 0;
    for (int i = 0; i < 3; i++) begin
      v2 = 1; s2 = (i == 0); p2 = 16'd65025; r2 = 0;
      @(posedge i_clk); #1;
    end
    v2 = 0;
`ifdef ACC_SATURATE_EN
    chk("ovf_sum", sum2, 131071);
`else
    chk("ovf_sum", sum2, 64003);
`endif
    chk("ovf_valid", sv2, 1);
    chk("ovf_flag", ov2, 1);
    @(posedge i_clk); #1;
    chk("ovf_sticky", ov2, 1);
    v2 = 1; s2 = 1; p2 = 16'd5; r2 = 1;
    @(posedge i_clk); #1;
    chk("ovf_cleared", ov2, 0);
    chk("ovf_next_valid", sv2, 0);
    v2 = 0; s2 = 0; r2 = 0;

    for (int i = 1; i <= 5; i++) step(1, i == 1, 16'd7, 1);
    #2 i_rst_n = 0;
    #1;
    chk("arst_in_ready", o_in_ready, 0);
    chk("arst_sum", o_sum, 0);
    chk("arst_valid", o_sum_valid, 0);
    chk("arst_overflow", o_overflow, 0);
    chk("arst_drop", o_drop, 0);
    m_hold = 0; m_busy = 0; m_acc = 0; m_n = 0; m_drop = 0;
    @(posedge i_clk); #1;
    i_rst_n = 1;
    for (int i = 0; i < 9; i++) step(1, i == 0, 16'd3, 0);
    chk("fresh_sum", o_sum, 27);
    step(0, 0, 0, 1);

    for (int i = 0; i < 400; i++)
      step($urandom_range(9, 0) < 7, $urandom_range(19, 0) < 3, 16'($urandom), $urandom_range(9, 0) < 6);
    repeat (3) step(0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
